// File: rtl/lfsr_bank.sv
// lfsr_bank: bank of Fibonacci LFSR channels sharing one tap mask, with handshaked per-channel seed loading
module lfsr_bank #(
  parameter int LFSR_LEN = 16,
  parameter int N_CH = 4,
  parameter logic [LFSR_LEN-1:0] DEFAULT_TAPS = LFSR_LEN'(16'h8016),
  localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     step_en,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CW-1:0]            cfg_ch,
  input  logic [LFSR_LEN-1:0]      cfg_seed,
  input  logic                     cfg_taps_we,
  input  logic [LFSR_LEN-1:0]      cfg_taps,
  output logic [N_CH*LFSR_LEN-1:0] rnd_out,
  output logic                     rnd_valid,
  output logic [N_CH-1:0]          lockup,
  output logic [LFSR_LEN-1:0]      step_cnt
);
  localparam logic [LFSR_LEN-1:0] MSB = {1'b1, {(LFSR_LEN-1){1'b0}}};
  typedef enum logic {RUN, LOAD} state_t;
  state_t state, state_nx;
  logic [LFSR_LEN-1:0] taps, ld_seed;
  logic [CW-1:0] ld_ch;
  logic accept;
  always_comb begin
    cfg_ready = state == RUN;
    accept = cfg_ready && cfg_valid;
    state_nx = accept ? LOAD : RUN;
  end
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= RUN;
      taps <= DEFAULT_TAPS | MSB;
      rnd_valid <= 1'b0;
      step_cnt <= '0;
    end else begin
      state <= state_nx;
      rnd_valid <= step_en;
      if (cfg_taps_we) taps <= cfg_taps | MSB;
      if (step_en) step_cnt <= step_cnt + LFSR_LEN'(1);
      if (accept) begin
        ld_ch <= cfg_ch;
        ld_seed <= cfg_seed;
      end
    end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [LFSR_LEN-1:0] r;
    logic lk, ld;
    assign ld = state == LOAD && ld_ch == CW'(c);
    // an all-zero register can never leave zero by shifting, so it is revived to 1
    always_ff @(posedge clk)
      if (!reset_n) begin
        r <= LFSR_LEN'(c + 1);
        lk <= 1'b0;
      end else if (ld) begin
        r <= ~|ld_seed ? LFSR_LEN'(1) : ld_seed;
        lk <= ~|ld_seed;
      end else if (step_en) begin
        r <= ~|r ? LFSR_LEN'(1) : {r[LFSR_LEN-2:0], ^(r & taps)};
        if (~|r) lk <= 1'b1;
      end
    assign rnd_out[c*LFSR_LEN +: LFSR_LEN] = r;
    assign lockup[c] = lk;
  end
endmodule
